// File: rtl/integral_image_gen_pkg.sv
// Shared face-detect constants, the frame-builder state type and a dimension check.
package integral_image_gen_pkg;

    localparam int FD_PIX_W    = 8;
    localparam int FD_II_W     = 32;
    localparam int FD_MAX_COLS = 1024;
    localparam int FD_ADDR_W   = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ii_state_t;

    // A frame needs at least one column and one row, and must fit the row buffer.
    function automatic logic dims_legal(input int unsigned width,
                                        input int unsigned height,
                                        input int unsigned max_cols);
        return (width >= 1) && (width <= max_cols) && (height >= 1);
    endfunction

endpackage

// File: rtl/integral_image_gen_row_buffer.sv
// One row of integral values: combinational read, synchronous write, no reset.
module integral_image_gen_row_buffer #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 10
) (
    input  logic              clk,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // A read at the index being written returns the previous row's value.
    assign rd_data = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/integral_image_gen.sv
// Streaming summed-area-table builder: raster pixels in, one integral value plus
// its linear address out per pixel, through a single registered output stage.
module integral_image_gen
    import integral_image_gen_pkg::*;
#(
    parameter int PIX_W    = FD_PIX_W,
    parameter int II_W     = FD_II_W,
    parameter int MAX_COLS = FD_MAX_COLS,
    parameter int ADDR_W   = FD_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] img_width,
    input  logic [ADDR_W-1:0] img_height,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  in_pixel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [II_W-1:0]   out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    ii_state_t         state;
    logic [ADDR_W-1:0] width_r;
    logic [ADDR_W-1:0] height_r;
    logic [ADDR_W-1:0] x;
    logic [ADDR_W-1:0] y;
    logic [ADDR_W-1:0] addr;
    logic [II_W-1:0]   row_sum;
    logic [II_W-1:0]   rd_data;
    logic [II_W-1:0]   row_sum_n;
    logic [II_W-1:0]   above;
    logic [II_W-1:0]   ii_value;
    logic              accept;
    logic              last_col;
    logic              last_row;

    // The output register is the only pipeline stage, so a new pixel may enter
    // exactly when that register is empty or draining this cycle.
    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);
    assign last_col = (x == width_r - ONE);
    assign last_row = (y == height_r - ONE);

    always_comb begin
        row_sum_n = ((x == '0) ? '0 : row_sum) + II_W'(in_pixel);
        above     = (y == '0) ? '0 : rd_data;
        ii_value  = row_sum_n + above;
    end

    integral_image_gen_row_buffer #(
        .DEPTH  (MAX_COLS),
        .DATA_W (II_W),
        .IDX_W  (IDX_W)
    ) u_row_buffer (
        .clk     (clk),
        .rd_idx  (x[IDX_W-1:0]),
        .rd_data (rd_data),
        .wr_en   (accept),
        .wr_idx  (x[IDX_W-1:0]),
        .wr_data (ii_value)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            width_r   <= '0;
            height_r  <= '0;
            x         <= '0;
            y         <= '0;
            addr      <= '0;
            row_sum   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && dims_legal(32'(img_width), 32'(img_height), MAX_COLS)) begin
                        width_r  <= img_width;
                        height_r <= img_height;
                        x        <= '0;
                        y        <= '0;
                        addr     <= '0;
                        row_sum  <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        out_valid <= 1'b1;
                        out_data  <= ii_value;
                        out_addr  <= addr;
                        addr      <= addr + ONE;
                        row_sum   <= row_sum_n;
                        if (last_col) begin
                            x <= '0;
                            y <= y + ONE;
                            if (last_row) begin
                                state <= DRAIN;
                            end
                        end else begin
                            x <= x + ONE;
                        end
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
